// File: rtl/note_fall_ctrl.sv
// note_fall_ctrl: one rhythm-game lane note that spawns, falls per frame, and resolves to hit, miss or flash.
module note_fall_ctrl #(
  parameter int          LANE_X       = 100,
  parameter int          WIDTH        = 64,
  parameter int          HEIGHT       = 32,
  parameter int          SPEED        = 4,
  parameter int          HIT_LINE_Y   = 600,
  parameter int          HIT_WINDOW   = 16,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [23:0] FLASH_COLOR  = 24'hFFFF00,
  parameter int          OFFSCREEN_Y  = 750
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        new_frame_in,
  input  logic        spawn_in,
  input  logic [23:0] spawn_color_in,
  input  logic        key_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [23:0] color_out,
  output logic        active_out,
  output logic        hit_out,
  output logic        miss_out
);
  typedef enum logic [1:0] {IDLE, FALL, FLASH} state_t;
  localparam int CW = $clog2(FLASH_FRAMES + 1);
  localparam logic [11:0] WIN_LO = 12'(HIT_LINE_Y - HIT_WINDOW);
  localparam logic [11:0] WIN_HI = 12'(HIT_LINE_Y + HIT_WINDOW);
  localparam logic [11:0] Y_MAX  = 12'(OFFSCREEN_Y - HEIGHT);
  localparam logic [9:0]  Y_OFF  = 10'(OFFSCREEN_Y);
  // The sprite box (LANE_X..LANE_X+WIDTH) must fit the 11-bit x coordinate space.
  if (WIDTH < 1 || LANE_X + WIDTH > 2048) begin : g_fit
    $error("note_fall_ctrl: lane sprite exceeds x range");
  end
  state_t         state_q;
  logic [9:0]     y_q;
  logic [23:0]    color_q;
  logic           active_q, hit_q, miss_q, key_q;
  logic [CW-1:0]  cnt_q;
  logic           press, in_win, miss_d;
  logic [10:0]    y_d;
  logic [11:0]    bot_q, bot_d;
  assign press  = key_in & ~key_q;
  assign y_d    = {1'b0, y_q} + 11'(SPEED);
  assign bot_q  = {2'b0, y_q} + 12'(HEIGHT);
  assign bot_d  = {1'b0, y_d} + 12'(HEIGHT);
  assign in_win = bot_q >= WIN_LO && bot_q <= WIN_HI;
  assign miss_d = bot_d > WIN_HI || {1'b0, y_d} > Y_MAX;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      y_q      <= Y_OFF;
      color_q  <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      key_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      key_q  <= key_in;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE: if (spawn_in) begin
          state_q  <= FALL;
          y_q      <= '0;
          color_q  <= spawn_color_in;
          active_q <= 1'b1;
        end
        // Hit is judged on the pre-move position and wins over a same-cycle frame step.
        FALL: if (press && in_win) begin
          state_q <= FLASH;
          hit_q   <= 1'b1;
          color_q <= FLASH_COLOR;
          cnt_q   <= '0;
        end else if (new_frame_in) begin
          if (miss_d) begin
            state_q  <= IDLE;
            miss_q   <= 1'b1;
            y_q      <= Y_OFF;
            color_q  <= '0;
            active_q <= 1'b0;
          end else begin
            y_q <= y_d[9:0];
          end
        end
        FLASH: if (new_frame_in) begin
          if (cnt_q == CW'(FLASH_FRAMES - 1)) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            y_q      <= Y_OFF;
            color_q  <= '0;
            active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign x_out      = 11'(LANE_X);
  assign y_out      = y_q;
  assign color_out  = color_q;
  assign active_out = active_q;
  assign hit_out    = hit_q;
  assign miss_out   = miss_q;
endmodule

// File: tb/tb_note_fall_ctrl.sv
// tb_note_fall_ctrl: directed lane scenarios plus random traffic against a behavioural note model.
module tb_note_fall_ctrl;
  logic        clk = 1'b0, rst = 1'b1, nf = 1'b0, sp = 1'b0, key = 1'b0;
  logic [23:0] spc = '0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [23:0] color_out;
  logic        active_out, hit_out, miss_out;
  int          total = 0, bad = 0;
  int          m_st = 0, m_y = 750, m_cnt = 0;
  logic [23:0] m_col = '0;
  bit          m_kp = 0, m_hit = 0, m_miss = 0;

  note_fall_ctrl dut (
    .clk_in(clk), .rst_in(rst), .new_frame_in(nf), .spawn_in(sp),
    .spawn_color_in(spc), .key_in(key), .x_out(x_out), .y_out(y_out),
    .color_out(color_out), .active_out(active_out), .hit_out(hit_out), .miss_out(miss_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Note model: m_st 0 = no note, 1 = falling, 2 = flashing after a hit.
  task automatic model_step();
    bit press;
    int ny;
    if (rst) begin
      m_st = 0; m_y = 750; m_col = '0; m_cnt = 0; m_kp = 0; m_hit = 0; m_miss = 0;
      return;
    end
    press = key && !m_kp;
    m_kp = key; m_hit = 0; m_miss = 0;
    case (m_st)
      0: if (sp) begin m_st = 1; m_y = 0; m_col = spc; end
      1: if (press && m_y + 32 >= 584 && m_y + 32 <= 616) begin
           m_st = 2; m_hit = 1; m_col = 24'hFFFF00; m_cnt = 0;
         end else if (nf) begin
           ny = m_y + 4;
           if (ny + 32 > 616 || ny > 718) begin m_st = 0; m_miss = 1; m_y = 750; m_col = '0; end
           else m_y = ny;
         end
      default: if (nf) begin
           m_cnt++;
           if (m_cnt == 8) begin m_st = 0; m_y = 750; m_col = '0; m_cnt = 0; end
         end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", {16'b0, x_out, y_out, color_out, active_out, hit_out, miss_out},
                 {16'b0, 11'd100, 10'(m_y), m_col, m_st != 0, m_hit, m_miss});
  endtask

  task automatic frame();
    nf = 1'b1; tick(); nf = 1'b0; tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    tick(); tick();
    chk("rst_y", y_out, 750); chk("rst_act", active_out, 0); chk("rst_col", color_out, 0);
    rst = 1'b0; spc = 24'h00FF00; sp = 1'b1; tick(); sp = 1'b0;
    chk("spawn_y", y_out, 0); chk("spawn_act", active_out, 1);
    frames(10);
    chk("fall_y", y_out, 40); chk("fall_col", color_out, 24'h00FF00); chk("fall_act", active_out, 1);
    frames(136);
    chk("pre_miss_y", y_out, 584);
    nf = 1'b1; tick(); nf = 1'b0;
    chk("miss_pulse", miss_out, 1); chk("miss_nohit", hit_out, 0);
    tick();
    chk("miss_clr", miss_out, 0); chk("miss_act", active_out, 0); chk("miss_y", y_out, 750);
    spc = 24'h123456; sp = 1'b1; tick(); sp = 1'b0;
    frames(137);
    chk("win_y548", y_out, 548);
    key = 1'b1; tick(); key = 1'b0;
    chk("early_hit", hit_out, 0); chk("early_col", color_out, 24'h123456);
    tick();
    frame();
    chk("win_y552", y_out, 552);
    key = 1'b1; tick(); key = 1'b0;
    chk("hit_pulse", hit_out, 1); chk("hit_col", color_out, 24'hFFFF00); chk("hit_y", y_out, 552);
    tick();
    chk("hit_clr", hit_out, 0);
    frames(7);
    chk("flash_act", active_out, 1); chk("flash_y", y_out, 552);
    frame();
    chk("flash_done", active_out, 0); chk("flash_done_y", y_out, 750);
    sp = 1'b1; tick(); sp = 1'b0;
    frames(146);
    key = 1'b1; nf = 1'b1; tick(); key = 1'b0; nf = 1'b0;
    chk("sim_hit", hit_out, 1); chk("sim_miss", miss_out, 0); chk("sim_y", y_out, 584);
    frames(8);
    chk("sim_idle", active_out, 0);
    key = 1'b1; tick();
    spc = 24'hABCDEF; sp = 1'b1; tick(); sp = 1'b0;
    frames(5);
    spc = 24'h111111; sp = 1'b1; tick(); sp = 1'b0;
    chk("respawn_y", y_out, 20); chk("respawn_col", color_out, 24'hABCDEF);
    frames(141);
    chk("held_y", y_out, 584); chk("held_nohit", hit_out, 0);
    nf = 1'b1; tick(); nf = 1'b0;
    chk("held_miss", miss_out, 1);
    key = 1'b0; tick();
    sp = 1'b1; tick(); sp = 1'b0;
    frames(50);
    chk("mid_y", y_out, 200);
    rst = 1'b1; sp = 1'b1; tick(); rst = 1'b0; sp = 1'b0;
    chk("abort_y", y_out, 750); chk("abort_act", active_out, 0); chk("abort_col", color_out, 0);
    chk("abort_pulses", {hit_out, miss_out}, 0);
    tick();
    chk("abort_nospawn", active_out, 0);
    for (int i = 0; i < 4000; i++) begin
      nf  = ($urandom_range(2) == 0);
      sp  = ($urandom_range(40) == 0);
      spc = 24'($urandom);
      if ($urandom_range(6) == 0) key = ~key;
      rst = ($urandom_range(1500) == 0);
      tick();
    end
    rst = 1'b0; nf = 1'b0; sp = 1'b0; key = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
